qcpu_spi_mem: RTL
=================

Name: qcpu_spi_mem

Overview:
Transaction sequencer that sits directly upstream of the byte-level SPI shifter. It turns a single-byte host read or write request into a framed SPI memory transaction: chip-select, command, address bytes, data byte, then chip-deselect. It drives the shifter through its start/din/busy/dout handshake and owns the CS_n pin.

Parameters:
ADDR_BYTES, 2, number of address bytes sent MSB-first (1..3)
CS_GAP, 2, minimum clk cycles CS_n stays high between frames (>=1)
CMD_READ, 8'h03, read command byte
CMD_WRITE, 8'h02, write command byte

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  1  host request, sampled only in IDLE
we  in  1  1 = write, 0 = read; latched on accept
addr  in  8*ADDR_BYTES  byte address; latched on accept
wdata  in  8  write data; latched on accept
rdata  out  8  read data; valid from ack onward until next accept
ack  out  1  one-cycle completion pulse
busy  out  1  high from accept cycle through ack cycle
CS_n  out  1  SPI chip select, active-low
spi_start  out  1  one-cycle start pulse to shifter
spi_din  out  8  byte to transmit; stable from start until shifter done
spi_busy  in  1  shifter busy
spi_dout  in  8  shifter received byte; valid when spi_busy low after a transfer

Behaviour:
- Reset values: CS_n=1, spi_start=0, spi_din=0, ack=0, busy=0, rdata=0, state=IDLE, gap counter=CS_GAP (gap already satisfied).
- States: IDLE -> SELECT -> SEND -> WAIT_HI -> WAIT_LO -> (next byte: SEND | DESELECT) -> GAP -> IDLE.
- IDLE: if req=1 and the gap counter has expired: latch we/addr/wdata, set busy=1, go to SELECT. req=0: stay.
- SELECT: CS_n<=0; load byte index 0; go to SEND next cycle (one cycle of CS setup before the first SCLK).
- Byte sequence: index 0 = CMD_READ/CMD_WRITE per we; indices 1..ADDR_BYTES = addr bytes MSB-first; last index = wdata (write) or 8'h00 (read). Total bytes = ADDR_BYTES+2.
- SEND: spi_din<=current byte, spi_start=1 for exactly one cycle; go to WAIT_HI.
- WAIT_HI: wait for spi_busy=1 (the shifter reports busy 2 cycles after start). Go to WAIT_LO when seen.
- WAIT_LO: wait for spi_busy=0. On the fall, if this was the last byte and we=0, rdata<=spi_dout. If bytes remain, advance the index and go to SEND; otherwise go to DESELECT.
- DESELECT: CS_n<=1, ack=1 for one cycle, busy deasserts the following cycle, gap counter reloads to 0; go to GAP.
- GAP: count up to CS_GAP, then go to IDLE. A req arriving during GAP is held off; the host must keep req asserted.
- Requests: req while busy=1 is ignored and not queued. A req held high in the cycle after ack starts a new transaction once the gap has elapsed.
- spi_din holds its value between a start and the next SEND. Only the last read byte updates rdata.
- Reset mid-transaction: CS_n=1 and spi_start=0 the cycle after rst; state=IDLE; no ack; the partial frame is abandoned (the shifter is reset by the same rst).
- spi_busy stuck high: the sequencer waits indefinitely; no timeout.

Optional Feature:
QCPU_SPI_MEM_WREN_EN
- Defined: each write is preceded by its own frame containing the single byte 8'h06 (write-enable). Sequence: CS_n low, 06, CS_n high for >= CS_GAP cycles, then the normal write frame. There is one ack, at the end of the write frame. Reads are unchanged.
- Undefined: no WREN frame; writes go straight to the write frame.

Test Plan:
- Read: ADDR_BYTES=2, req with we=0, addr=16'h1234; slave model returns A5 on the 4th byte -> MOSI bytes 03,12,34,00 within one CS_n low window; rdata=8'hA5; ack exactly one cycle; busy falls the cycle after ack.
- Write: we=1, addr=16'h5678, wdata=8'h3C -> MOSI bytes 02,56,78,3C; ack pulse; rdata unchanged from its previous value.
- WREN_EN defined, write to 16'h0001 with 8'hFF -> frame {06}; CS_n high >=2 cycles; frame {02,00,01,FF}; exactly one ack.
- Request while busy: second req pulse issued during ADDR -> ignored; exactly one frame and one ack.
- Back-to-back: req held high continuously -> the second frame's CS_n falls no earlier than CS_GAP cycles after the first frame's CS_n rises.
- Reset mid-ADDR -> CS_n=1 the next cycle, no ack, busy=0; a following read of 16'h0000 completes correctly.

Source files
------------

// File: rtl/qcpu_spi_mem.sv
// Frames single-byte host reads/writes into SPI memory transactions.
// Define QCPU_SPI_MEM_WREN_EN to send a WREN (06) frame before every write.
module qcpu_spi_mem #(
  parameter int          ADDR_BYTES = 2,
  parameter int          CS_GAP     = 2,
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter logic [7:0]  CMD_WRITE  = 8'h02
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [8*ADDR_BYTES-1:0] addr,
  input  logic [7:0]              wdata,
  output logic [7:0]              rdata,
  output logic                    ack,
  output logic                    busy,
  output logic                    CS_n,
  output logic                    spi_start,
  output logic [7:0]              spi_din,
  input  logic                    spi_busy,
  input  logic [7:0]              spi_dout
);

  localparam int         GW   = $clog2(CS_GAP + 1);
  localparam logic [2:0] LAST = 3'(ADDR_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, SEND, WAIT_HI, WAIT_LO, DESELECT, GAP
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic                    wren_q, wren_d;
  logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [2:0]              idx_q, idx_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [7:0]              rdata_d, din_d, cur_byte;
  logic                    ack_d, busy_d, cs_d, start_d;
  logic [2:0]              last_idx;

  // The WREN frame is a single byte, so it ends at index 0
  assign last_idx = wren_q ? 3'd0 : LAST;

  always_comb begin
    cur_byte = 8'h00;
    if (wren_q)
      cur_byte = 8'h06;
    else if (idx_q == 3'd0)
      cur_byte = we_q ? CMD_WRITE : CMD_READ;
    else if (idx_q == LAST)
      cur_byte = we_q ? wdata_q : 8'h00;
    else
      for (int i = 1; i <= ADDR_BYTES; i++)
        if (idx_q == 3'(i))
          cur_byte = addr_q[8*(ADDR_BYTES-i) +: 8];
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    wren_d  = wren_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    rdata_d = rdata;
    din_d   = spi_din;
    busy_d  = busy;
    cs_d    = CS_n;
    ack_d   = 1'b0;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && gap_q >= GW'(CS_GAP)) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          busy_d  = 1'b1;
          state_d = SELECT;
`ifdef QCPU_SPI_MEM_WREN_EN
          wren_d  = we;
`else
          wren_d  = 1'b0;
`endif
        end
      end
      SELECT: begin
        cs_d    = 1'b0;
        idx_d   = 3'd0;
        state_d = SEND;
      end
      SEND: begin
        din_d   = cur_byte;
        start_d = 1'b1;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (spi_busy)
          state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!spi_busy) begin
          if (idx_q == last_idx) begin
            if (!we_q && !wren_q)
              rdata_d = spi_dout;
            state_d = DESELECT;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      DESELECT: begin
        cs_d    = 1'b1;
        ack_d   = !wren_q;
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (!wren_q)
          busy_d = 1'b0;
        gap_d = gap_q + GW'(1);
        // After WREN the write frame follows without returning to IDLE
        if (int'(gap_q) + 1 >= CS_GAP) begin
          state_d = wren_q ? SELECT : IDLE;
          wren_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      idx_q     <= 3'd0;
      gap_q     <= GW'(CS_GAP);
      rdata     <= 8'h00;
      spi_din   <= 8'h00;
      busy      <= 1'b0;
      CS_n      <= 1'b1;
      ack       <= 1'b0;
      spi_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      rdata     <= rdata_d;
      spi_din   <= din_d;
      busy      <= busy_d;
      CS_n      <= cs_d;
      ack       <= ack_d;
      spi_start <= start_d;
    end
  end

endmodule
